banked_mem: RTL and testbench

Parametrised multi-bank on-chip memory with byte-enable writes, a ready/valid read port with in-order backpressure, optional output register, selectable read-during-write behaviour and a hardware zero-initialisation sweep. It is the next-generation weight/activation store for the quantised inference datapath. It replaces single flat arrays wherever consumers can stall or buffers must be cleared between layers.

---
 rtl/banked_mem.sv | 166 ++++++++++++++++
 tb/tb_banked_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem.sv
// Multi-bank memory: byte-enable writes, in-order ready/valid reads with a small
// response buffer, selectable read-during-write behaviour and a zeroing sweep.
module banked_mem #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned OUT_REG   = 1,
  parameter int unsigned BYPASS    = 1,
  localparam int unsigned AW = $clog2(DEPTH * NUM_BANKS),
  localparam int unsigned BW = $clog2(NUM_BANKS),
  localparam int unsigned NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [WIDTH-1:0] rdata,
  input  logic             init_start,
  output logic             init_busy,
  output logic             init_done
);

  localparam int unsigned L   = 1 + OUT_REG;
  localparam int unsigned FD  = L + 1;
  localparam int unsigned PW  = $clog2(FD);
  localparam int unsigned CW  = $clog2(FD + 1);
  localparam int unsigned RW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BWS = (BW > 0) ? BW : 1;

  typedef enum logic [1:0] {IDLE, INIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    init_busy = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      IDLE: if (init_start) begin
        state_d = INIT;
        row_d   = '0;
      end
      INIT: begin
        init_busy = 1'b1;
        if (row_q == RW'(DEPTH - 1)) state_d = DONE;
        else                         row_d   = row_q + RW'(1);
      end
      DONE: begin
        init_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  logic             wr_fire, rd_fire, pop;
  logic [BWS-1:0]   wr_bank, rd_bank;
  logic [RW-1:0]    wr_row, rd_row;
  logic [WIDTH-1:0] bank_rd [NUM_BANKS];
  logic [WIDTH-1:0] rd_word;
  logic [CW-1:0]    cnt_q, cnt_d, occ_q, occ_d;

  assign wr_fire = wr_en && (state_q == IDLE);
  assign rd_ready = (state_q == IDLE) && (cnt_q <= CW'(L));
  assign rd_fire = rd_valid && rd_ready;
  assign wr_bank = BWS'(wr_addr % NUM_BANKS);
  assign rd_bank = BWS'(rd_addr % NUM_BANKS);
  assign wr_row  = RW'(wr_addr >> BW);
  assign rd_row  = RW'(rd_addr >> BW);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (state_q == INIT) begin
        mem[row_q] <= '0;
      end else if (wr_fire && wr_bank == BWS'(b)) begin
        for (int unsigned i = 0; i < NB; i++)
          if (wr_be[i]) mem[wr_row][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    assign bank_rd[b] = mem[rd_row];
  end

  // Write-first merge happens before capture, so later writes cannot reach an accepted read.
  always_comb begin
    rd_word = bank_rd[rd_bank];
    if (BYPASS != 0 && wr_fire && wr_addr == rd_addr) begin
      for (int unsigned i = 0; i < NB; i++)
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  logic             push;
  logic [WIDTH-1:0] push_data;

  if (OUT_REG != 0) begin : g_oreg
    logic             s1_v_q;
    logic [WIDTH-1:0] s1_d_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v_q <= 1'b0;
        s1_d_q <= '0;
      end else begin
        s1_v_q <= rd_fire;
        if (rd_fire) s1_d_q <= rd_word;
      end
    end
    assign push      = s1_v_q;
    assign push_data = s1_d_q;
  end else begin : g_noreg
    assign push      = rd_fire;
    assign push_data = rd_word;
  end

  // Buffer holds L+1 words; the outstanding count covers the pipeline stage too, so push never overflows.
  logic [WIDTH-1:0] fifo_q [FD];
  logic [PW-1:0]    wp_q, rp_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rdata_valid = (occ_q != '0);
  assign rdata       = fifo_q[rp_q];
  assign pop         = rdata_valid && rdata_ready;
  assign cnt_d       = cnt_q + CW'(rd_fire) - CW'(pop);
  assign occ_d       = occ_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FD; i++) fifo_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      occ_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wp_q] <= push_data;
        wp_q         <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem: a queue/array model checked every cycle, plus literal spot checks.
module tb_banked_mem;
  localparam int unsigned WIDTH = 32, DEPTH = 256, NUM_BANKS = 4, OUT_REG = 1, BYPASS = 1;
  localparam int unsigned N = DEPTH * NUM_BANKS;
  localparam int unsigned L = 1 + OUT_REG;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_valid = 1'b0, rdata_ready = 1'b1, init_start = 1'b0;
  logic [9:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_ready, rdata_valid, init_busy, init_done;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  banked_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS), .OUT_REG(OUT_REG), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .rdata(rdata), .init_start(init_start), .init_busy(init_busy),
    .init_done(init_done));

  int unsigned vec = 0, errs = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Model: flat word array, response queue stamped with its due cycle, and a mode counter.
  typedef struct { logic [31:0] d; int unsigned due; } rsp_t;
  logic [31:0] mmem [N];
  rsp_t        q [$];
  int unsigned cyc = 0, outst = 0, phase = 0, srow = 0;

  function automatic bit m_valid();
    return q.size() > 0 && q[0].due <= cyc;
  endfunction

  function automatic bit m_rdy();
    return phase == 0 && outst <= L;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      outst = 0;
      phase = 0;
      srow  = 0;
    end else begin : upd
      bit acc, pp;
      rsp_t r;
      acc = rd_valid && m_rdy();
      pp  = m_valid() && rdata_ready;
      if (pp) void'(q.pop_front());
      if (acc) begin
        r.d = mmem[rd_addr];
        if (BYPASS != 0 && phase == 0 && wr_en && wr_addr == rd_addr) r.d = merge(r.d, wr_data, wr_be);
        r.due = cyc + L;
        q.push_back(r);
      end
      if (phase == 0 && wr_en) mmem[wr_addr] = merge(mmem[wr_addr], wr_data, wr_be);
      case (phase)
        0: if (init_start) begin phase = 1; srow = 0; end
        1: begin
          for (int b = 0; b < NUM_BANKS; b++) mmem[srow * NUM_BANKS + b] = '0;
          srow++;
          if (srow == DEPTH) phase = 2;
        end
        default: phase = 0;
      endcase
      outst = outst + (acc ? 1 : 0) - (pp ? 1 : 0);
      cyc++;
    end
  end

  bit          chk_on = 1'b0;
  int unsigned dut_pops = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("rd_ready", 32'(rd_ready), 32'(m_rdy()));
      check("rdata_valid", 32'(rdata_valid), 32'(m_valid()));
      check("init_busy", 32'(init_busy), 32'(phase == 1));
      check("init_done", 32'(init_done), 32'(phase == 2));
      if (m_valid()) check("rdata", rdata, q[0].d);
      if (rdata_valid && rdata_ready) dut_pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one(input string nm, input logic [9:0] a, input logic [31:0] exp,
                          input logic w, input logic [31:0] wd, input logic [3:0] wbe);
    rd_valid = 1'b1; rd_addr = a;
    wr_en = w; wr_addr = a; wr_data = wd; wr_be = wbe;
    tick();
    rd_valid = 1'b0; wr_en = 1'b0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    check({nm, "_valid"}, 32'(rdata_valid), 1);
    check(nm, rdata, exp);
    tick();
  endtask

  task automatic stream_all();
    int unsigned p0, low;
    p0 = dut_pops; low = 0;
    for (int unsigned i = 0; i < N; i++) begin
      rd_valid = 1'b1; rd_addr = 10'(i);
      @(negedge clk);
      if (!rd_ready) low++;
      tick();
    end
    rd_valid = 1'b0;
    repeat (L + 2) tick();
    check("stream_pops", dut_pops - p0, N);
    check("stream_rd_ready_low", low, 0);
  endtask

  initial begin : stim
    int unsigned acc, p0, nbusy, done_at;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    #1;
    check("rst_rd_ready", 32'(rd_ready), 1);
    check("rst_rdata_valid", 32'(rdata_valid), 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_init_busy", 32'(init_busy), 0);
    check("rst_init_done", 32'(init_done), 0);
    tick();

    // byte enables
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hAABBCCDD; wr_be = 4'b1111; tick();
    wr_data = 32'h11223344; wr_be = 4'b0101; tick();
    wr_en = 1'b0;
    read_one("byte_enable", 10'd5, 32'hAA22CC44, 1'b0, 32'h0, 4'b0);

    // bank interleave fill and back-to-back readback
    for (int unsigned i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = i; wr_be = 4'b1111; tick();
    end
    wr_en = 1'b0;
    stream_all();
    read_one("spot_2c6", 10'h2C6, 32'h0000_02C6, 1'b0, 32'h0, 4'b0);

    // read-during-write
    wr_en = 1'b1; wr_addr = 10'd9; wr_data = 32'h0; wr_be = 4'b1111; tick();
    wr_en = 1'b0;
    read_one("rdw", 10'd9, (BYPASS != 0) ? 32'h0000FFFF : 32'h0, 1'b1, 32'hFFFFFFFF, 4'b0011);
    read_one("rdw_after", 10'd9, 32'h0000FFFF, 1'b0, 32'h0, 4'b0);

    // backpressure
    rdata_ready = 1'b0; acc = 0;
    for (int k = 0; k < 8; k++) begin
      rd_valid = 1'b1; rd_addr = 10'(100 + acc);
      @(negedge clk);
      if (rd_ready) acc++;
      tick();
    end
    rd_valid = 1'b0;
    check("bp_accepted", acc, L + 1);
    p0 = dut_pops; rdata_ready = 1'b1;
    repeat (L + 4) tick();
    check("bp_pops", dut_pops - p0, L + 1);

    // init sweep with a coincident write, then writes/reads/starts during the sweep
    init_start = 1'b1; wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
    tick();
    init_start = 1'b0; wr_en = 1'b0;
    nbusy = 0; done_at = 0;
    for (int unsigned c = 1; c <= DEPTH + 2; c++) begin
      wr_en      = (c == 5);
      wr_addr    = 10'd8; wr_data = 32'hCAFEF00D;
      init_start = (c == 10);
      rd_valid   = (c == 20); rd_addr = 10'd3;
      @(negedge clk);
      if (init_busy) nbusy++;
      if (init_done) done_at = c;
      tick();
    end
    wr_en = 1'b0; init_start = 1'b0; rd_valid = 1'b0;
    check("sweep_busy_cycles", nbusy, DEPTH);
    check("sweep_done_cycle", done_at, DEPTH + 1);
    read_one("post_sweep_7", 10'd7, 32'h0, 1'b0, 32'h0, 4'b0);
    read_one("post_sweep_8", 10'd8, 32'h0, 1'b0, 32'h0, 4'b0);
    stream_all();

    // reset mid-backpressure
    rdata_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd1;
    repeat (5) tick();
    rd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstbp_rdata_valid", 32'(rdata_valid), 0);
    check("rstbp_rdata", rdata, 32'h0);
    check("rstbp_rd_ready", 32'(rd_ready), 1);
    tick();
    rdata_ready = 1'b1; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rstbp_no_stale", 32'(rdata_valid), 0);
      tick();
    end

    // reset mid-sweep
    init_start = 1'b1; tick();
    init_start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstsw_init_busy", 32'(init_busy), 0);
    check("rstsw_init_done", 32'(init_done), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstsw_rd_ready", 32'(rd_ready), 1);
      check("rstsw_busy", 32'(init_busy), 0);
      tick();
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
